// File: rtl/alu_issue_stage_if.sv
// Request/result bus for alu_issue_stage: an input valid/ready request
// channel and an output valid/ready result channel.
interface alu_issue_stage_if #(
    parameter int W = 4
);
    // request channel
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   in_op;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;

    // result channel
    logic         out_valid;
    logic         out_ready;
    logic [2:0]   out_op;
    logic [W-1:0] out_res;
    logic         out_zero;
    logic         out_overflow;
    logic         out_carry;

    // producer of requests / consumer of results
    modport master (
        output in_valid, in_op, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_op, out_res,
               out_zero, out_overflow, out_carry
    );

    // the issue stage itself
    modport slave (
        input  in_valid, in_op, in_a, in_b, out_ready,
        output in_ready, out_valid, out_op, out_res,
               out_zero, out_overflow, out_carry
    );
endinterface

// File: rtl/alu_issue_stage.sv
// Two-register issue stage around an external combinational 4-bit ALU.
// Stage 1 holds the accepted request and drives the ALU inputs; stage 2
// captures the ALU result/flags for a downstream valid/ready consumer.
// Also counts completed results and completed add/sub overflows.
module alu_issue_stage #(
    parameter int W    = 4,
    parameter int CNTW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    alu_issue_stage_if.slave bus,
    output logic [2:0]      alu_fnselec,
    output logic [W-1:0]    alu_a,
    output logic [W-1:0]    alu_b,
    input  logic [W-1:0]    alu_res,
    input  logic            alu_zero,
    input  logic            alu_overflow,
    input  logic            alu_carry,
    output logic [CNTW-1:0] op_count,
    output logic [CNTW-1:0] ovf_count
);
    // stage 1: accepted request
    logic            s1_valid_reg;
    logic [2:0]      s1_op_reg;
    logic [W-1:0]    s1_a_reg;
    logic [W-1:0]    s1_b_reg;

    // stage 2: ALU result and flags
    logic            s2_valid_reg;
    logic [2:0]      s2_op_reg;
    logic [W-1:0]    s2_res_reg;
    logic            s2_zero_reg;
    logic            s2_overflow_reg;
    logic            s2_carry_reg;

    // statistics
    logic [CNTW-1:0] op_count_reg;
    logic [CNTW-1:0] op_count_next;
    logic [CNTW-1:0] ovf_count_reg;
    logic [CNTW-1:0] ovf_count_next;

    logic out_fire;
    logic s2_adv;
    logic in_ready;
    logic in_fire;
    logic ovf_hit;

    // handshake terms; in_ready looks through to out_ready so a full pipe
    // can still accept while it drains
    assign out_fire = s2_valid_reg && bus.out_ready;
    assign s2_adv   = s1_valid_reg && (!s2_valid_reg || bus.out_ready);
    assign in_ready = !flush && (!s1_valid_reg || s2_adv);
    assign in_fire  = bus.in_valid && in_ready;

    // only add/sub overflows are counted, and the counter sticks at all-ones
    assign ovf_hit = out_fire && s2_overflow_reg && (s2_op_reg[2:1] == 2'b00)
                     && (ovf_count_reg != {CNTW{1'b1}});

    // stage 1 register: load on accept, release on advance or flush
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s1_op_reg    <= '0;
            s1_a_reg     <= '0;
            s1_b_reg     <= '0;
        end else if (in_fire) begin
            s1_valid_reg <= 1'b1;
            s1_op_reg    <= bus.in_op;
            s1_a_reg     <= bus.in_a;
            s1_b_reg     <= bus.in_b;
        end else if (flush || s2_adv) begin
            s1_valid_reg <= 1'b0;
        end
    end

    // stage 2 register: capture ALU output on advance, release on consume
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_reg    <= 1'b0;
            s2_op_reg       <= '0;
            s2_res_reg      <= '0;
            s2_zero_reg     <= 1'b0;
            s2_overflow_reg <= 1'b0;
            s2_carry_reg    <= 1'b0;
        end else if (flush) begin
            s2_valid_reg <= 1'b0;
        end else if (s2_adv) begin
            s2_valid_reg    <= 1'b1;
            s2_op_reg       <= s1_op_reg;
            s2_res_reg      <= alu_res;
            s2_zero_reg     <= alu_zero;
            s2_overflow_reg <= alu_overflow;
            s2_carry_reg    <= alu_carry;
        end else if (out_fire) begin
            s2_valid_reg <= 1'b0;
        end
    end

    // next counter values: op_count wraps, ovf_count saturates via ovf_hit
    always_comb begin
        op_count_next  = op_count_reg;
        ovf_count_next = ovf_count_reg;
        if (out_fire) begin
            op_count_next = op_count_reg + CNTW'(1);
        end
        if (ovf_hit) begin
            ovf_count_next = ovf_count_reg + CNTW'(1);
        end
    end

    // counter registers; flush does not touch them
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_count_reg  <= '0;
            ovf_count_reg <= '0;
        end else begin
            op_count_reg  <= op_count_next;
            ovf_count_reg <= ovf_count_next;
        end
    end

    assign bus.in_ready     = in_ready;
    assign alu_fnselec      = s1_op_reg;
    assign alu_a            = s1_a_reg;
    assign alu_b            = s1_b_reg;
    assign bus.out_valid    = s2_valid_reg;
    assign bus.out_op       = s2_op_reg;
    assign bus.out_res      = s2_res_reg;
    assign bus.out_zero     = s2_zero_reg;
    assign bus.out_overflow = s2_overflow_reg;
    assign bus.out_carry    = s2_carry_reg;
    assign op_count         = op_count_reg;
    assign ovf_count        = ovf_count_reg;
endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: behavioural ALU, queue-based reference model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_alu_issue_stage;
    logic clk = 1'b0;
    logic rst;
    logic flush;
    logic force_ovf;
    always #5 clk = ~clk;

    alu_issue_stage_if #(.W(4)) bus();

    logic [2:0] alu_fnselec;
    logic [3:0] alu_a, alu_b, alu_res;
    logic       alu_zero, alu_overflow, alu_carry;
    logic [7:0] op_count, ovf_count;

    alu_issue_stage #(.W(4), .CNTW(8)) dut (
        .clk(clk), .rst(rst), .flush(flush), .bus(bus),
        .alu_fnselec(alu_fnselec), .alu_a(alu_a), .alu_b(alu_b),
        .alu_res(alu_res), .alu_zero(alu_zero),
        .alu_overflow(alu_overflow), .alu_carry(alu_carry),
        .op_count(op_count), .ovf_count(ovf_count)
    );

    typedef struct packed {
        logic [2:0] op;
        logic [3:0] res;
        logic       z;
        logic       v;
        logic       c;
    } item_t;

    // behavioural 4-bit ALU; fo forces the overflow flag
    function automatic item_t alu_model(input logic [2:0] op, input logic [3:0] a,
                                        input logic [3:0] b, input logic fo);
        item_t r;
        logic [4:0] s;
        r = '0;
        s = '0;
        r.op = op;
        case (op)
            3'd0: begin
                s = {1'b0, a} + {1'b0, b};
                r.res = s[3:0]; r.c = s[4];
                r.v = (a[3] == b[3]) && (r.res[3] != a[3]);
            end
            3'd1: begin
                s = {1'b0, a} - {1'b0, b};
                r.res = s[3:0]; r.c = s[4];
                r.v = (a[3] != b[3]) && (r.res[3] != a[3]);
            end
            3'd2: r.res = ~a;
            3'd3: r.res = a & b;
            3'd4: r.res = a | b;
            3'd5: r.res = a ^ b;
            3'd6: r.res = {3'b000, a < b};
            default: r.res = {3'b000, a == b};
        endcase
        r.z = (r.res == 4'd0);
        r.v = r.v | fo;
        return r;
    endfunction

    item_t alu_now;
    assign alu_now      = alu_model(alu_fnselec, alu_a, alu_b, force_ovf);
    assign alu_res      = alu_now.res;
    assign alu_zero     = alu_now.z;
    assign alu_overflow = alu_now.v;
    assign alu_carry    = alu_now.c;

    int nchecks = 0;
    int nfail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        nchecks++;
        if (act !== req) begin
            nfail++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    // reference model: in-order queue of up to two results; "fresh" marks
    // an entry accepted at the latest edge, which is not yet visible
    item_t      q[$];
    bit         fresh;
    logic [2:0] m_op;
    logic [3:0] m_a, m_b;
    int         m_ops, m_ovf;

    function automatic bit exp_out_valid();
        return (q.size() == 2) || (q.size() == 1 && !fresh);
    endfunction

    // model advance at each clock edge
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            fresh = 0; m_op = '0; m_a = '0; m_b = '0; m_ops = 0; m_ovf = 0;
        end else begin
            bit ofire, ifire;
            item_t h;
            ofire = exp_out_valid() && bus.out_ready;
            ifire = bus.in_valid && !flush && (q.size() < 2 || bus.out_ready);
            if (ofire) begin
                h = q.pop_front();
                m_ops = (m_ops + 1) % 256;
                if (h.v && h.op <= 3'd1 && m_ovf < 255) m_ovf++;
            end
            if (flush) q.delete();
            if (ifire) begin
                q.push_back(alu_model(bus.in_op, bus.in_a, bus.in_b, force_ovf));
                m_op = bus.in_op; m_a = bus.in_a; m_b = bus.in_b;
                fresh = 1;
            end else begin
                fresh = 0;
            end
        end
    end

    // compare DUT against model on every falling edge
    always @(negedge clk) begin
        if (!rst) begin
            chk("in_ready", 32'(bus.in_ready), 32'(!flush && (q.size() < 2 || bus.out_ready)));
            chk("out_valid", 32'(bus.out_valid), 32'(exp_out_valid()));
            if (exp_out_valid() && q.size() > 0) begin
                chk("out_op", 32'(bus.out_op), 32'(q[0].op));
                chk("out_res", 32'(bus.out_res), 32'(q[0].res));
                chk("out_zero", 32'(bus.out_zero), 32'(q[0].z));
                chk("out_overflow", 32'(bus.out_overflow), 32'(q[0].v));
                chk("out_carry", 32'(bus.out_carry), 32'(q[0].c));
            end
            chk("alu_fnselec", 32'(alu_fnselec), 32'(m_op));
            chk("alu_a", 32'(alu_a), 32'(m_a));
            chk("alu_b", 32'(alu_b), 32'(m_b));
            chk("op_count", 32'(op_count), 32'(m_ops));
            chk("ovf_count", 32'(ovf_count), 32'(m_ovf));
        end
    end

    // offer one request until accepted (bounded)
    task automatic send(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        int n = 0;
        bit done = 0;
        bus.in_valid = 1'b1; bus.in_op = op; bus.in_a = a; bus.in_b = b;
        while (!done) begin
            @(negedge clk);
            if (bus.in_ready) done = 1;
            @(posedge clk); #1;
            n++;
            if (!done && n > 50) begin
                chk("send_timeout", 32'(0), 32'(1));
                done = 1;
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int saved;
        rst = 1'b1; flush = 1'b0; force_ovf = 1'b0;
        bus.in_valid = 1'b0; bus.in_op = '0; bus.in_a = '0; bus.in_b = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // reset state
        chk("rst_out_valid", 32'(bus.out_valid), 32'(0));
        chk("rst_out_res", 32'(bus.out_res), 32'(0));
        chk("rst_alu_a", 32'(alu_a), 32'(0));
        chk("rst_op_count", 32'(op_count), 32'(0));

        // add then sub with out_ready high
        bus.out_ready = 1'b1;
        send(3'd0, 4'd3, 4'd4);
        send(3'd1, 4'd5, 4'd5);
        chk("add_valid", 32'(bus.out_valid), 32'(1));
        chk("add_res", 32'(bus.out_res), 32'(7));
        chk("add_zero", 32'(bus.out_zero), 32'(0));
        chk("add_carry", 32'(bus.out_carry), 32'(0));
        @(posedge clk); #1;
        chk("sub_res", 32'(bus.out_res), 32'(0));
        chk("sub_zero", 32'(bus.out_zero), 32'(1));
        @(posedge clk); #1;
        chk("addsub_op_count", 32'(op_count), 32'(2));
        drain();

        // backpressure: two accepted, third held off, head stable
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_op = 3'd0; bus.in_a = 4'd1; bus.in_b = 4'd1;
        @(negedge clk); chk("bp_rdy1", 32'(bus.in_ready), 32'(1));
        @(posedge clk); #1 bus.in_a = 4'd2; bus.in_b = 4'd2;
        @(negedge clk); chk("bp_rdy2", 32'(bus.in_ready), 32'(1));
        @(posedge clk); #1 bus.in_a = 4'd3; bus.in_b = 4'd3;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_rdy3", 32'(bus.in_ready), 32'(0));
            chk("bp_hold", 32'(bus.out_res), 32'(2));
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        @(negedge clk); chk("bp_out2", 32'(bus.out_res), 32'(2));
        @(posedge clk); #1 bus.in_valid = 1'b0;
        @(negedge clk);
        chk("bp_v4", 32'(bus.out_valid), 32'(1));
        chk("bp_out4", 32'(bus.out_res), 32'(4));
        @(negedge clk);
        chk("bp_v6", 32'(bus.out_valid), 32'(1));
        chk("bp_out6", 32'(bus.out_res), 32'(6));
        drain();

        // overflow counting, saturation and op_count wrap
        do_reset();
        send(3'd0, 4'd7, 4'd1);
        drain();
        chk("ovf_res", 32'(bus.out_res), 32'(8));
        chk("ovf_flag", 32'(bus.out_overflow), 32'(1));
        chk("ovf_count1", 32'(ovf_count), 32'(1));
        force_ovf = 1'b1;
        send(3'd5, 4'd3, 4'd5);
        drain();
        force_ovf = 1'b0;
        chk("xor_flag_pass", 32'(bus.out_overflow), 32'(1));
        chk("xor_ovf_count", 32'(ovf_count), 32'(1));
        for (int i = 0; i < 254; i++) send(3'd0, 4'd7, 4'd1);
        drain();
        chk("ovf_255", 32'(ovf_count), 32'(255));
        chk("wrap_256", 32'(op_count), 32'(0));
        send(3'd0, 4'd7, 4'd1);
        drain();
        chk("ovf_sat", 32'(ovf_count), 32'(255));
        chk("wrap_257", 32'(op_count), 32'(1));

        // flush with both stages full and a request offered
        bus.out_ready = 1'b0;
        send(3'd0, 4'd1, 4'd2);
        send(3'd0, 4'd2, 4'd3);
        saved = int'(op_count);
        bus.in_valid = 1'b1; bus.in_op = 3'd4; bus.in_a = 4'd1; bus.in_b = 4'd1;
        flush = 1'b1;
        @(negedge clk); chk("flush_rdy", 32'(bus.in_ready), 32'(0));
        @(posedge clk); #1;
        flush = 1'b0; bus.in_valid = 1'b0;
        chk("flush_valid", 32'(bus.out_valid), 32'(0));
        chk("flush_cnt", 32'(op_count), 32'(saved));
        bus.out_ready = 1'b1;
        send(3'd4, 4'd9, 4'd6);
        @(posedge clk); #1;
        chk("post_flush_v", 32'(bus.out_valid), 32'(1));
        chk("post_flush_res", 32'(bus.out_res), 32'(15));
        drain();

        // randomized traffic with occasional flush
        repeat (3000) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_op     = 3'($urandom_range(0, 7));
            bus.in_a      = 4'($urandom_range(0, 15));
            bus.in_b      = 4'($urandom_range(0, 15));
            bus.out_ready = ($urandom_range(0, 3) != 0);
            flush         = ($urandom_range(0, 19) == 0);
            @(posedge clk); #1;
        end
        flush = 1'b0;
        drain();

        // asynchronous reset between edges with both stages full
        bus.out_ready = 1'b0;
        send(3'd0, 4'd1, 4'd1);
        send(3'd0, 4'd2, 4'd2);
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(bus.out_valid), 32'(0));
        chk("arst_ops", 32'(op_count), 32'(0));
        chk("arst_ovf", 32'(ovf_count), 32'(0));
        chk("arst_alu_a", 32'(alu_a), 32'(0));
        @(posedge clk); #1 rst = 1'b0;
        bus.out_ready = 1'b1;
        send(3'd3, 4'd12, 4'd10);
        @(posedge clk); #1;
        chk("arst_and_v", 32'(bus.out_valid), 32'(1));
        chk("arst_and_res", 32'(bus.out_res), 32'(8));
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
        $finish;
    end
endmodule
